io_core_regs: RTL and testbench

- Holds the core-internal I/O registers: SPL, SPH, SREG, RAMPZ and EIND.
- Feeds spl_out/sph_out/sreg_out/rampz_out/eind_out directly into the I/O read decoder/multiplexer.
- Accepts I/O-space writes from the core data bus.
- Performs stack-pointer adjustment for PUSH/POP/CALL/RET/interrupt entry.
- Performs per-flag SREG updates from the ALU and I-flag control for interrupts.

---
 rtl/io_core_regs_if.sv | 34 +++
 rtl/io_core_regs.sv | 108 ++++++++++
 tb/tb_io_core_regs.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/io_core_regs_if.sv
// Bus bundle between the core and its internal I/O register block (SP, SREG, RAMPZ, EIND).
// The core drives the write/adjust/flag inputs; the register block returns the register outputs.
interface io_core_regs_if;
    logic [5:0]  adr;
    logic        iowe;
    logic [7:0]  dbusout;
    logic        sp_push;
    logic        sp_pop;
    logic [1:0]  sp_delta;
    logic [7:0]  sreg_fl_in;
    logic [7:0]  sreg_fl_we;
    logic        irq_entry;
    logic        reti;

    logic [7:0]  spl_out;
    logic [7:0]  sph_out;
    logic [15:0] sp_out;
    logic [7:0]  sreg_out;
    logic [7:0]  rampz_out;
    logic [7:0]  eind_out;
    logic        sp_err;

    modport master (
        output adr, iowe, dbusout, sp_push, sp_pop, sp_delta,
               sreg_fl_in, sreg_fl_we, irq_entry, reti,
        input  spl_out, sph_out, sp_out, sreg_out, rampz_out, eind_out, sp_err
    );

    modport slave (
        input  adr, iowe, dbusout, sp_push, sp_pop, sp_delta,
               sreg_fl_in, sreg_fl_we, irq_entry, reti,
        output spl_out, sph_out, sp_out, sreg_out, rampz_out, eind_out, sp_err
    );
endinterface

// File: rtl/io_core_regs.sv
// Core-internal I/O registers: stack pointer with push/pop adjust and wrap detection,
// SREG with per-flag ALU updates and interrupt I-flag control, RAMPZ and EIND.
module io_core_regs #(
    parameter bit          pc22b      = 1'b0,
    parameter logic [15:0] sp_rst_val = 16'h10FF,
    parameter bit          rampz_impl = 1'b1
) (
    input  logic          cp2,
    input  logic          ireset,
    io_core_regs_if.slave bus
);
    localparam logic [5:0] ADR_RAMPZ = 6'h3B;
    localparam logic [5:0] ADR_EIND  = 6'h3C;
    localparam logic [5:0] ADR_SPL   = 6'h3D;
    localparam logic [5:0] ADR_SPH   = 6'h3E;
    localparam logic [5:0] ADR_SREG  = 6'h3F;

    logic [15:0] sp_q, sp_d;
    logic [7:0]  sreg_q, sreg_d;
    logic [7:0]  rampz_q, rampz_d;
    logic [7:0]  eind_q, eind_d;
    logic        sp_err_q, sp_err_d;

    logic        wrSpl, wrSph, wrSreg, wrRampz, wrEind;
    logic [15:0] spDelta;
    logic [16:0] spDown, spUp;

    assign wrSpl   = bus.iowe && (bus.adr == ADR_SPL);
    assign wrSph   = bus.iowe && (bus.adr == ADR_SPH);
    assign wrSreg  = bus.iowe && (bus.adr == ADR_SREG);
    assign wrRampz = bus.iowe && (bus.adr == ADR_RAMPZ) && rampz_impl;
    assign wrEind  = bus.iowe && (bus.adr == ADR_EIND) && pc22b;

    // A zero delta means one byte; three bytes only exist with a 22-bit PC.
    always_comb begin
        spDelta = 16'd1;
        case (bus.sp_delta)
            2'd2:    spDelta = 16'd2;
            2'd3:    spDelta = pc22b ? 16'd3 : 16'd2;
            default: spDelta = 16'd1;
        endcase
    end

    // Bit 16 of each result is the borrow/carry that flags a stack wrap.
    assign spDown = {1'b0, sp_q} - {1'b0, spDelta};
    assign spUp   = {1'b0, sp_q} + {1'b0, spDelta};

    always_comb begin
        sp_d     = sp_q;
        sp_err_d = sp_err_q;
        if (wrSpl) begin
            sp_d[7:0] = bus.dbusout;
        end else if (wrSph) begin
            sp_d[15:8] = bus.dbusout;
            sp_err_d   = 1'b0;
        end else if (bus.sp_push && !bus.sp_pop) begin
            sp_d = spDown[15:0];
            if (spDown[16]) sp_err_d = 1'b1;
        end else if (bus.sp_pop && !bus.sp_push) begin
            sp_d = spUp[15:0];
            if (spUp[16]) sp_err_d = 1'b1;
        end
    end

    // A direct SREG write masks the ALU flags and the interrupt I-flag control.
    always_comb begin
        sreg_d = sreg_q;
        if (wrSreg) begin
            sreg_d = bus.dbusout;
        end else begin
            sreg_d = (sreg_q & ~bus.sreg_fl_we) | (bus.sreg_fl_in & bus.sreg_fl_we);
            if (bus.irq_entry) begin
                sreg_d[7] = 1'b0;
            end else if (bus.reti) begin
                sreg_d[7] = 1'b1;
            end
        end
    end

    always_comb begin
        rampz_d = wrRampz ? bus.dbusout : rampz_q;
        eind_d  = wrEind  ? bus.dbusout : eind_q;
    end

    always_ff @(posedge cp2) begin
        if (ireset) begin
            sp_q     <= sp_rst_val;
            sreg_q   <= 8'h00;
            rampz_q  <= 8'h00;
            eind_q   <= 8'h00;
            sp_err_q <= 1'b0;
        end else begin
            sp_q     <= sp_d;
            sreg_q   <= sreg_d;
            rampz_q  <= rampz_d;
            eind_q   <= eind_d;
            sp_err_q <= sp_err_d;
        end
    end

    assign bus.spl_out   = sp_q[7:0];
    assign bus.sph_out   = sp_q[15:8];
    assign bus.sp_out    = sp_q;
    assign bus.sreg_out  = sreg_q;
    assign bus.rampz_out = rampz_q;
    assign bus.eind_out  = eind_q;
    assign bus.sp_err    = sp_err_q;
endmodule

// File: tb/tb_io_core_regs.sv
// Scoreboard bench for io_core_regs: one instance with a 16-bit PC and no RAMPZ,
// one with a 22-bit PC and RAMPZ, both fed the same directed vectors.
module tb_io_core_regs;
    typedef struct packed {
        logic       ireset;
        logic [5:0] adr;
        logic       iowe;
        logic [7:0] dbusout;
        logic       sp_push;
        logic       sp_pop;
        logic [1:0] sp_delta;
        logic [7:0] fl_in;
        logic [7:0] fl_we;
        logic       irq_entry;
        logic       reti;
    } stim_t;

    // Expected view: {sp_out, sph_out, spl_out, sreg, rampz, eind, sp_err}
    typedef struct {
        string       name;
        logic [56:0] expA;
        logic [56:0] expB;
    } exp_t;

    logic  cp2;
    stim_t drv;
    stim_t nxt;
    exp_t  expQ[$];
    int    checks;
    int    failures;

    io_core_regs_if busA ();
    io_core_regs_if busB ();

    io_core_regs #(.pc22b(1'b0), .sp_rst_val(16'h10FF), .rampz_impl(1'b0)) dutA (
        .cp2(cp2), .ireset(drv.ireset), .bus(busA.slave)
    );
    io_core_regs #(.pc22b(1'b1), .sp_rst_val(16'h10FF), .rampz_impl(1'b1)) dutB (
        .cp2(cp2), .ireset(drv.ireset), .bus(busB.slave)
    );

    assign busA.adr = drv.adr;           assign busB.adr = drv.adr;
    assign busA.iowe = drv.iowe;         assign busB.iowe = drv.iowe;
    assign busA.dbusout = drv.dbusout;   assign busB.dbusout = drv.dbusout;
    assign busA.sp_push = drv.sp_push;   assign busB.sp_push = drv.sp_push;
    assign busA.sp_pop = drv.sp_pop;     assign busB.sp_pop = drv.sp_pop;
    assign busA.sp_delta = drv.sp_delta; assign busB.sp_delta = drv.sp_delta;
    assign busA.sreg_fl_in = drv.fl_in;  assign busB.sreg_fl_in = drv.fl_in;
    assign busA.sreg_fl_we = drv.fl_we;  assign busB.sreg_fl_we = drv.fl_we;
    assign busA.irq_entry = drv.irq_entry; assign busB.irq_entry = drv.irq_entry;
    assign busA.reti = drv.reti;         assign busB.reti = drv.reti;

    initial cp2 = 1'b0;
    always #5 cp2 = ~cp2;

    function automatic logic [56:0] mk(input logic [15:0] sp, input logic [7:0] sreg,
                                       input logic [7:0] rampz, input logic [7:0] eind,
                                       input logic err);
        return {sp, sp[15:8], sp[7:0], sreg, rampz, eind, err};
    endfunction

    function automatic void clearInputs();
        nxt = '0;
        nxt.sp_delta = 2'd1;
    endfunction

    function automatic void ioWrite(input logic [5:0] a, input logic [7:0] d);
        nxt.iowe    = 1'b1;
        nxt.adr     = a;
        nxt.dbusout = d;
    endfunction

    // Staged inputs are applied on the falling edge together with their expectation.
    task automatic applyStimulus(input string name, input logic [56:0] eA, input logic [56:0] eB);
        exp_t e;
        @(negedge cp2);
        drv    = nxt;
        e.name = name;
        e.expA = eA;
        e.expB = eB;
        expQ.push_back(e);
        clearInputs();
    endtask

    task automatic checkOutput(input string name, input string inst,
                               input logic [56:0] act, input logic [56:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s/%s: got sp=%h sph=%h spl=%h sreg=%h rampz=%h eind=%h err=%b, expected sp=%h sph=%h spl=%h sreg=%h rampz=%h eind=%h err=%b",
                     name, inst, act[56:41], act[40:33], act[32:25], act[24:17], act[16:9], act[8:1], act[0],
                     exp[56:41], exp[40:33], exp[32:25], exp[24:17], exp[16:9], exp[8:1], exp[0]);
        end
    endtask

    always @(posedge cp2) begin
        exp_t e;
        #1;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e.name, "pc16", {busA.sp_out, busA.sph_out, busA.spl_out, busA.sreg_out,
                                         busA.rampz_out, busA.eind_out, busA.sp_err}, e.expA);
            checkOutput(e.name, "pc22", {busB.sp_out, busB.sph_out, busB.spl_out, busB.sreg_out,
                                         busB.rampz_out, busB.eind_out, busB.sp_err}, e.expB);
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        clearInputs();
        drv = nxt;
        drv.ireset = 1'b1;

        nxt.ireset = 1'b1;
        applyStimulus("reset", mk(16'h10FF, 8'h00, 8'h00, 8'h00, 1'b0), mk(16'h10FF, 8'h00, 8'h00, 8'h00, 1'b0));
        ioWrite(6'h3E, 8'h08);
        applyStimulus("wr_sph", mk(16'h08FF, 8'h00, 8'h00, 8'h00, 1'b0), mk(16'h08FF, 8'h00, 8'h00, 8'h00, 1'b0));
        ioWrite(6'h3D, 8'hFF);
        applyStimulus("wr_spl", mk(16'h08FF, 8'h00, 8'h00, 8'h00, 1'b0), mk(16'h08FF, 8'h00, 8'h00, 8'h00, 1'b0));
        nxt.sp_push = 1'b1; nxt.sp_delta = 2'd2;
        applyStimulus("push2", mk(16'h08FD, 8'h00, 8'h00, 8'h00, 1'b0), mk(16'h08FD, 8'h00, 8'h00, 8'h00, 1'b0));
        nxt.sp_pop = 1'b1; nxt.sp_delta = 2'd1;
        applyStimulus("pop1", mk(16'h08FE, 8'h00, 8'h00, 8'h00, 1'b0), mk(16'h08FE, 8'h00, 8'h00, 8'h00, 1'b0));
        ioWrite(6'h3E, 8'h00);
        applyStimulus("wr_sph0", mk(16'h00FE, 8'h00, 8'h00, 8'h00, 1'b0), mk(16'h00FE, 8'h00, 8'h00, 8'h00, 1'b0));
        ioWrite(6'h3D, 8'h01);
        applyStimulus("wr_spl1", mk(16'h0001, 8'h00, 8'h00, 8'h00, 1'b0), mk(16'h0001, 8'h00, 8'h00, 8'h00, 1'b0));
        nxt.sp_push = 1'b1; nxt.sp_delta = 2'd2;
        applyStimulus("push_wrap", mk(16'hFFFF, 8'h00, 8'h00, 8'h00, 1'b1), mk(16'hFFFF, 8'h00, 8'h00, 8'h00, 1'b1));
        nxt.sp_pop = 1'b1; nxt.sp_delta = 2'd1;
        applyStimulus("pop_sticky", mk(16'h0000, 8'h00, 8'h00, 8'h00, 1'b1), mk(16'h0000, 8'h00, 8'h00, 8'h00, 1'b1));
        ioWrite(6'h3E, 8'h10);
        applyStimulus("sph_clr_err", mk(16'h1000, 8'h00, 8'h00, 8'h00, 1'b0), mk(16'h1000, 8'h00, 8'h00, 8'h00, 1'b0));
        ioWrite(6'h3D, 8'h55); nxt.sp_push = 1'b1;
        applyStimulus("spl_beats_push", mk(16'h1055, 8'h00, 8'h00, 8'h00, 1'b0), mk(16'h1055, 8'h00, 8'h00, 8'h00, 1'b0));
        nxt.sp_push = 1'b1; nxt.sp_pop = 1'b1;
        applyStimulus("push_and_pop", mk(16'h1055, 8'h00, 8'h00, 8'h00, 1'b0), mk(16'h1055, 8'h00, 8'h00, 8'h00, 1'b0));
        nxt.sp_push = 1'b1; nxt.sp_delta = 2'd0;
        applyStimulus("push_delta0", mk(16'h1054, 8'h00, 8'h00, 8'h00, 1'b0), mk(16'h1054, 8'h00, 8'h00, 8'h00, 1'b0));
        nxt.sp_pop = 1'b1; nxt.sp_delta = 2'd3;
        applyStimulus("pop_delta3", mk(16'h1056, 8'h00, 8'h00, 8'h00, 1'b0), mk(16'h1057, 8'h00, 8'h00, 8'h00, 1'b0));
        nxt.sp_push = 1'b1; nxt.sp_delta = 2'd3;
        applyStimulus("push_delta3", mk(16'h1054, 8'h00, 8'h00, 8'h00, 1'b0), mk(16'h1054, 8'h00, 8'h00, 8'h00, 1'b0));
        ioWrite(6'h3F, 8'h00);
        applyStimulus("wr_sreg0", mk(16'h1054, 8'h00, 8'h00, 8'h00, 1'b0), mk(16'h1054, 8'h00, 8'h00, 8'h00, 1'b0));
        nxt.fl_we = 8'h03; nxt.fl_in = 8'hFF;
        applyStimulus("flag_we03", mk(16'h1054, 8'h03, 8'h00, 8'h00, 1'b0), mk(16'h1054, 8'h03, 8'h00, 8'h00, 1'b0));
        nxt.reti = 1'b1;
        applyStimulus("reti", mk(16'h1054, 8'h83, 8'h00, 8'h00, 1'b0), mk(16'h1054, 8'h83, 8'h00, 8'h00, 1'b0));
        nxt.irq_entry = 1'b1; nxt.reti = 1'b1; nxt.fl_we = 8'h80; nxt.fl_in = 8'h80;
        applyStimulus("irq_beats_all", mk(16'h1054, 8'h03, 8'h00, 8'h00, 1'b0), mk(16'h1054, 8'h03, 8'h00, 8'h00, 1'b0));
        ioWrite(6'h3F, 8'hA5); nxt.irq_entry = 1'b1;
        applyStimulus("wr_sreg_wins", mk(16'h1054, 8'hA5, 8'h00, 8'h00, 1'b0), mk(16'h1054, 8'hA5, 8'h00, 8'h00, 1'b0));
        nxt.fl_we = 8'h0F; nxt.fl_in = 8'h00; nxt.sp_push = 1'b1;
        applyStimulus("flags_with_push", mk(16'h1053, 8'hA0, 8'h00, 8'h00, 1'b0), mk(16'h1053, 8'hA0, 8'h00, 8'h00, 1'b0));
        ioWrite(6'h3C, 8'h01);
        applyStimulus("wr_eind", mk(16'h1053, 8'hA0, 8'h00, 8'h00, 1'b0), mk(16'h1053, 8'hA0, 8'h00, 8'h01, 1'b0));
        ioWrite(6'h3B, 8'h7A);
        applyStimulus("wr_rampz", mk(16'h1053, 8'hA0, 8'h00, 8'h00, 1'b0), mk(16'h1053, 8'hA0, 8'h7A, 8'h01, 1'b0));
        ioWrite(6'h3A, 8'hFF);
        applyStimulus("wr_unmapped", mk(16'h1053, 8'hA0, 8'h00, 8'h00, 1'b0), mk(16'h1053, 8'hA0, 8'h7A, 8'h01, 1'b0));
        ioWrite(6'h3E, 8'hFF);
        applyStimulus("wr_sphFF", mk(16'hFF53, 8'hA0, 8'h00, 8'h00, 1'b0), mk(16'hFF53, 8'hA0, 8'h7A, 8'h01, 1'b0));
        ioWrite(6'h3D, 8'hFF);
        applyStimulus("wr_splFF", mk(16'hFFFF, 8'hA0, 8'h00, 8'h00, 1'b0), mk(16'hFFFF, 8'hA0, 8'h7A, 8'h01, 1'b0));
        nxt.sp_pop = 1'b1; nxt.sp_delta = 2'd2;
        applyStimulus("pop_wrap", mk(16'h0001, 8'hA0, 8'h00, 8'h00, 1'b1), mk(16'h0001, 8'hA0, 8'h7A, 8'h01, 1'b1));
        nxt.ireset = 1'b1; nxt.sp_pop = 1'b1; nxt.fl_we = 8'hFF; nxt.fl_in = 8'hFF;
        applyStimulus("reset_wins", mk(16'h10FF, 8'h00, 8'h00, 8'h00, 1'b0), mk(16'h10FF, 8'h00, 8'h00, 8'h00, 1'b0));
        applyStimulus("idle", mk(16'h10FF, 8'h00, 8'h00, 8'h00, 1'b0), mk(16'h10FF, 8'h00, 8'h00, 8'h00, 1'b0));

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge cp2);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
